// File: rtl/ifetch_pkg.sv
// Shared encodings for the instruction-fetch stage: jump types, opcodes and FSM states.
// Big-endian bit numbering ([0] = MSB) matches the decode stage this feeds.
package ifetch_pkg;

    localparam logic [0:31] RESET_PC = 32'h0000_0000;

    localparam logic [0:1] JT_NONE   = 2'b00;
    localparam logic [0:1] JT_BRANCH = 2'b01;
    localparam logic [0:1] JT_JUMP   = 2'b10;
    localparam logic [0:1] JT_JREG   = 2'b11;

    localparam logic [0:5] OP_R    = 6'h00;
    localparam logic [0:5] OP_FPR  = 6'h01;
    localparam logic [0:5] OP_J    = 6'h02;
    localparam logic [0:5] OP_JAL  = 6'h03;
    localparam logic [0:5] OP_JALR = 6'h13;

    localparam logic [0:31] NOP = 32'h0000_0000;

    typedef enum logic {
        FETCH,
        DRAIN
    } fetch_state_t;

endpackage

// File: rtl/ifetch_target.sv
// Combinational redirect resolution: decides whether decode's jump/branch is taken
// and computes the new PC (all targets wrap mod 2^32).
module ifetch_target
    import ifetch_pkg::*;
(
    input  logic [0:1]  i_jump_type,
    input  logic        i_branch_cond,
    input  logic [0:31] i_cond_val,
    input  logic [0:31] i_reg_target,
    input  logic [0:31] i_dec_pc4,
    input  logic [0:25] i_dec_offset,
    output logic        o_taken,
    output logic [0:31] o_target
);

    logic w_cond_hit;

    assign w_cond_hit = ((i_cond_val != '0) == i_branch_cond);
    // Bit [0] of the jump type is its MSB: set for both unconditional jump kinds.
    assign o_taken    = ((i_jump_type == JT_BRANCH) && w_cond_hit) || i_jump_type[0];

    always_comb begin
        o_target = i_dec_pc4;
        case (i_jump_type)
            JT_JREG:   o_target = i_reg_target;
            JT_JUMP:   o_target = i_dec_pc4 + {{6{i_dec_offset[0]}}, i_dec_offset};
            JT_BRANCH: o_target = i_dec_pc4 + {{16{i_dec_offset[10]}}, i_dec_offset[10:25]};
            JT_NONE:   o_target = i_dec_pc4;
            default:   o_target = i_dec_pc4;
        endcase
    end

endmodule

// File: rtl/ifetch.sv
// Instruction-fetch stage: owns the PC, drives the req/ack imem port, buffers one
// instruction for decode and applies decode's redirects with wrong-path squashing.
module ifetch
    import ifetch_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    output logic        IMemReq,
    output logic [0:31] IMemAddr,
    input  logic        IMemAck,
    input  logic [0:31] IMemData,
    input  logic [0:1]  JumpType,
    input  logic        BranchCond,
    input  logic [0:31] CondVal,
    input  logic [0:31] RegTarget,
    input  logic [0:31] DecPCPlusFour,
    input  logic [0:25] DecOffset,
    output logic [0:5]  NextOpCode,
    output logic [0:5]  NextFunction,
    output logic [0:4]  NextRs1,
    output logic [0:4]  NextRs2,
    output logic [0:4]  NextRd,
    output logic [0:15] NextImmd,
    output logic [0:31] NextPCPlusFour
);

    fetch_state_t r_state;
    logic [0:31]  r_pc;
    logic [0:31]  r_drain_addr;
    logic [0:31]  r_instr;
    logic [0:31]  r_pc4;
    logic         r_full;

    logic         w_taken;
    logic [0:31]  w_target;
    logic         w_accept;
    logic         w_redirect;
    logic         w_ack;
    logic [0:31]  w_word;

    ifetch_target u_target (
        .i_jump_type  (JumpType),
        .i_branch_cond(BranchCond),
        .i_cond_val   (CondVal),
        .i_reg_target (RegTarget),
        .i_dec_pc4    (DecPCPlusFour),
        .i_dec_offset (DecOffset),
        .o_taken      (w_taken),
        .o_target     (w_target)
    );

    assign w_accept   = !r_full || !stall;
    assign w_redirect = w_taken && !stall;
    // Requests in FETCH only go out when the ack is guaranteed to be accepted.
    assign IMemReq    = reset && ((r_state == DRAIN) || w_accept);
    assign IMemAddr   = (r_state == DRAIN) ? r_drain_addr : r_pc;
    assign w_ack      = IMemAck && IMemReq;

    assign w_word         = r_full ? r_instr : NOP;
    assign NextOpCode     = w_word[0:5];
    assign NextRs1        = w_word[6:10];
    assign NextRs2        = w_word[11:15];
    assign NextImmd       = w_word[16:31];
    assign NextFunction   = w_word[26:31];
    assign NextPCPlusFour = r_full ? r_pc4 : '0;

    always_comb begin
        NextRd = w_word[11:15];
        if ((w_word[0:5] == OP_R) || (w_word[0:5] == OP_FPR))
            NextRd = w_word[16:20];
        else if ((w_word[0:5] == OP_JAL) || (w_word[0:5] == OP_JALR))
            NextRd = 5'd31;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= FETCH;
            r_pc         <= RESET_PC;
            r_drain_addr <= '0;
            r_instr      <= '0;
            r_pc4        <= '0;
            r_full       <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_redirect) begin
                        r_pc   <= w_target;
                        r_full <= 1'b0;
                        // Unacked request must still complete at its old address.
                        if (!w_ack) begin
                            r_drain_addr <= r_pc;
                            r_state      <= DRAIN;
                        end
                    end else if (w_ack && w_accept) begin
                        r_instr <= IMemData;
                        r_pc4   <= r_pc + 32'd4;
                        r_pc    <= r_pc + 32'd4;
                        r_full  <= 1'b1;
                    end else if (!stall) begin
                        r_full <= 1'b0;
                    end
                end
                DRAIN: begin
                    r_full <= 1'b0;
                    if (w_redirect)
                        r_pc <= w_target;
                    if (w_ack)
                        r_state <= FETCH;
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_ifetch.sv
// Self-checking bench for ifetch: variable-latency memory model feeding a scoreboard
// of expected fetched words, plus directed checks of redirect, stall and reset behaviour.
module tb_ifetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        IMemReq;
    logic [31:0] IMemAddr;
    logic        IMemAck;
    logic [31:0] IMemData;
    logic [1:0]  JumpType;
    logic        BranchCond;
    logic [31:0] CondVal;
    logic [31:0] RegTarget;
    logic [31:0] DecPCPlusFour;
    logic [25:0] DecOffset;
    logic [5:0]  NextOpCode;
    logic [5:0]  NextFunction;
    logic [4:0]  NextRs1;
    logic [4:0]  NextRs2;
    logic [4:0]  NextRd;
    logic [15:0] NextImmd;
    logic [31:0] NextPCPlusFour;

    typedef struct {
        logic [31:0] pc4;
        logic [31:0] word;
    } sb_entry_t;

    sb_entry_t   sb_q[$];
    int unsigned n_checks;
    int unsigned n_pass;
    int unsigned lat;
    int unsigned cnt;
    logic        tb_redirect;
    logic        drain_pending;
    logic [74:0] w_next_all;

    ifetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .IMemReq       (IMemReq),
        .IMemAddr      (IMemAddr),
        .IMemAck       (IMemAck),
        .IMemData      (IMemData),
        .JumpType      (JumpType),
        .BranchCond    (BranchCond),
        .CondVal       (CondVal),
        .RegTarget     (RegTarget),
        .DecPCPlusFour (DecPCPlusFour),
        .DecOffset     (DecOffset),
        .NextOpCode    (NextOpCode),
        .NextFunction  (NextFunction),
        .NextRs1       (NextRs1),
        .NextRs2       (NextRs2),
        .NextRd        (NextRd),
        .NextImmd      (NextImmd),
        .NextPCPlusFour(NextPCPlusFour)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_next_all = {NextOpCode, NextFunction, NextRs1, NextRs2, NextRd, NextImmd, NextPCPlusFour};

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        case (addr)
            32'h200: mem_word = {6'h00, 5'd3, 5'd4, 5'd5, 5'd0, 6'h20};
            32'h204: mem_word = {6'h03, 26'h0000010};
            32'h208: mem_word = {6'h13, 5'd9, 21'h0};
            default: mem_word = {6'h08, 5'd2, 5'd7, addr[15:0]};
        endcase
    endfunction

    function automatic logic [4:0] exp_rd(input logic [31:0] w);
        logic [5:0] op;
        op = w[31:26];
        if (op == 6'h00 || op == 6'h01)      exp_rd = w[15:11];
        else if (op == 6'h03 || op == 6'h13) exp_rd = 5'd31;
        else                                 exp_rd = w[20:16];
    endfunction

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_pc4(input string tag, input logic [31:0] v, input int unsigned budget);
        for (int unsigned i = 0; i < budget; i++) begin
            step();
            if (NextPCPlusFour == v) break;
        end
        chk(tag, NextPCPlusFour, v);
    endtask

    // Memory model: ack after `lat` extra cycles of a held request.
    assign IMemAck  = IMemReq && (cnt >= lat);
    assign IMemData = IMemAck ? mem_word(IMemAddr) : 32'h0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= 0;
        end else begin
            if (IMemReq && !IMemAck) cnt <= cnt + 1;
            else                     cnt <= 0;
            if (IMemAck) begin
                if (drain_pending)     drain_pending = 1'b0;
                else if (!tb_redirect) sb_q.push_back('{IMemAddr + 32'd4, mem_word(IMemAddr)});
            end else if (tb_redirect) begin
                drain_pending = 1'b1;
            end
        end
    end

    // Decode side: consumes the presented instruction on every unstalled edge.
    always @(negedge clk) begin
        sb_entry_t e;
        #3;
        if (reset && !stall && NextPCPlusFour != 32'h0) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected", NextPCPlusFour, 32'h0);
            end else begin
                e = sb_q.pop_front();
                chk("sb_pc4", NextPCPlusFour, e.pc4);
                chk("sb_word", {NextOpCode, NextRs1, NextRs2, NextImmd}, e.word);
                chk("sb_func", NextFunction, e.word[5:0]);
                chk("sb_rd", NextRd, exp_rd(e.word));
            end
        end
    end

    initial begin
        n_checks = 0; n_pass = 0; lat = 0;
        tb_redirect = 1'b0; drain_pending = 1'b0;
        reset = 1'b0; stall = 1'b0; JumpType = 2'b00; BranchCond = 1'b0;
        CondVal = '0; RegTarget = '0; DecPCPlusFour = '0; DecOffset = '0;

        step(); step();
        chk("rst_req", IMemReq, 1'b0);
        chk("rst_next", w_next_all, '0);
        reset = 1'b1;
        #1;
        chk("first_req", IMemReq, 1'b1);
        chk("first_addr", IMemAddr, 32'h0);
        for (int unsigned k = 1; k <= 4; k++) begin
            step();
            chk("seq_pc4", NextPCPlusFour, 32'(4 * k));
        end

        // Stall with a full buffer
        stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            #1;
            chk("stall_pc4", NextPCPlusFour, 32'h10);
            chk("stall_req", IMemReq, 1'b0);
            chk("stall_addr", IMemAddr, 32'h10);
            step();
        end
        stall = 1'b0;
        #1;
        chk("unstall_req", IMemReq, 1'b1);
        step();
        chk("unstall_pc4", NextPCPlusFour, 32'h14);

        // BEQZ taken
        JumpType = 2'b01; BranchCond = 1'b0; CondVal = 32'h0;
        DecPCPlusFour = 32'h20; DecOffset = 26'h0000010; tb_redirect = 1'b1;
        step();
        JumpType = 2'b00; tb_redirect = 1'b0;
        chk("beqz_nop", w_next_all, '0);
        chk("beqz_addr", IMemAddr, 32'h30);
        step();
        chk("beqz_pc4", NextPCPlusFour, 32'h34);
        chk("beqz_immd", NextImmd, 16'h0030);
        chk("def_rd", NextRd, 5'd7);

        // BNEZ with zero operand: not taken
        JumpType = 2'b01; BranchCond = 1'b1; CondVal = 32'h0;
        step();
        JumpType = 2'b00;
        chk("bnez_pc4", NextPCPlusFour, 32'h38);

        // JAL backwards by 8
        JumpType = 2'b10; DecPCPlusFour = 32'h44; DecOffset = 26'h3FFFFF8; tb_redirect = 1'b1;
        step();
        JumpType = 2'b00; tb_redirect = 1'b0;
        chk("jal_nop", w_next_all, '0);
        chk("jal_addr", IMemAddr, 32'h3C);
        step();
        chk("jal_pc4", NextPCPlusFour, 32'h40);

        // JR into the decode-test words
        JumpType = 2'b11; RegTarget = 32'h200; tb_redirect = 1'b1;
        step();
        JumpType = 2'b00; tb_redirect = 1'b0;
        chk("jr_addr", IMemAddr, 32'h200);
        step();
        chk("r_op", NextOpCode, 6'h00);
        chk("r_rd", NextRd, 5'd5);
        chk("r_func", NextFunction, 6'h20);
        step();
        chk("jal_op", NextOpCode, 6'h03);
        chk("jal_rd", NextRd, 5'd31);
        step();
        chk("jalr_rd", NextRd, 5'd31);

        // JR while a slow request is outstanding forces a drain
        JumpType = 2'b11; RegTarget = 32'h20; tb_redirect = 1'b1;
        step();
        JumpType = 2'b00; tb_redirect = 1'b0;
        chk("pre_addr", IMemAddr, 32'h20);
        step();
        lat = 2;
        #1;
        chk("slow_addr", IMemAddr, 32'h24);
        step();
        JumpType = 2'b11; RegTarget = 32'h100; tb_redirect = 1'b1;
        step();
        JumpType = 2'b00; tb_redirect = 1'b0;
        chk("drain_req", IMemReq, 1'b1);
        chk("drain_addr", IMemAddr, 32'h24);
        chk("drain_nop", w_next_all, '0);
        step();
        chk("post_drain_addr", IMemAddr, 32'h100);
        wait_pc4("drain_target_pc4", 32'h104, 10);

        // Reset mid-request
        reset = 1'b0;
        sb_q.delete();
        drain_pending = 1'b0;
        #1;
        chk("midrst_req", IMemReq, 1'b0);
        chk("midrst_next", w_next_all, '0);
        step(); step();
        chk("hold_rst_next", w_next_all, '0);
        reset = 1'b1;
        #1;
        chk("rel_addr", IMemAddr, 32'h0);
        chk("rel_req", IMemReq, 1'b1);
        wait_pc4("rel_pc4", 32'h4, 10);
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
